// File: rtl/vram_tile_blitter.sv
// Tile blitter: copies a 32x32 tile from one of three tile ROMs into VRAM at (dst_x,dst_y),
// sharing the single VRAM write port with CPU writes, which always take priority.
module vram_tile_blitter #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 400,
  parameter logic [11:0] KEY_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  src_sel,
  input  logic [9:0]  dst_x,
  input  logic [8:0]  dst_y,
  input  logic        key_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        cpu_vram_we,
  input  logic [17:0] cpu_vram_addr,
  input  logic [11:0] cpu_vram_data,
  output logic [9:0]  background_addr,
  input  logic [11:0] background_data,
  output logic [9:0]  character_addr,
  input  logic [11:0] character_data,
  output logic [9:0]  wall_addr,
  input  logic [11:0] wall_data,
  output logic        vram_we,
  output logic [17:0] vram_addr,
  output logic [11:0] vram_data
);

  localparam int unsigned KW = 10;
  localparam int unsigned VW = 18;
  localparam int unsigned PW = 12;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] SRC_BG   = 2'd0;
  localparam logic [1:0] SRC_CHR  = 2'd1;
  localparam logic [1:0] SRC_WALL = 2'd2;
  localparam logic [1:0] SRC_BAD  = 2'd3;

  localparam logic [KW-1:0] K_LAST = 10'd1023;

  logic [1:0]    state, state_n;
  logic [KW-1:0] k, k_n;
  logic [KW-1:0] rom_addr, rom_addr_n;
  logic [1:0]    src, src_n;
  logic [9:0]    dx, dx_n;
  logic [8:0]    dy, dy_n;
  logic          key, key_n;
  logic [PW-1:0] hold, hold_n;
  logic          holding, holding_n;
  logic          busy_n, done_n, err_n;
  logic          vram_we_n;
  logic [VW-1:0] vram_addr_n;
  logic [PW-1:0] vram_data_n;

  logic [PW-1:0] rom_q;
  logic [PW-1:0] px_data;
  logic [10:0]   px_x;
  logic [9:0]    px_y;
  logic [VW-1:0] px_addr;
  logic          px_keep;
  logic [10:0]   k_plus2;

  // Read data of the ROM selected by the latched source
  always_comb begin
    rom_q = '0;
    case (src)
      SRC_BG:   rom_q = background_data;
      SRC_CHR:  rom_q = character_data;
      SRC_WALL: rom_q = wall_data;
      default:  rom_q = '0;
    endcase
  end

  // Current pixel position, VRAM address and keep/clip decision
  always_comb begin
    px_data = holding ? hold : rom_q;
    px_x    = 11'(dx) + 11'(k[4:0]);
    px_y    = 10'(dy) + 10'(k[9:5]);
    px_addr = VW'(20'(px_y) * 20'(H_RES) + 20'(px_x));
    px_keep = (px_x < 11'(H_RES)) && (px_y < 10'(V_RES)) &&
              !(key && (px_data == KEY_COLOR));
    k_plus2 = 11'(k) + 11'd2;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n     = state;
    k_n         = k;
    rom_addr_n  = rom_addr;
    src_n       = src;
    dx_n        = dx;
    dy_n        = dy;
    key_n       = key;
    hold_n      = hold;
    holding_n   = holding;
    done_n      = 1'b0;
    err_n       = 1'b0;
    vram_we_n   = 1'b0;
    vram_addr_n = vram_addr;
    vram_data_n = vram_data;

    case (state)
      S_IDLE: begin
        rom_addr_n = '0;
        if (start) begin
          if (src_sel == SRC_BAD) begin
            done_n = 1'b1;
            err_n  = 1'b1;
          end else begin
            state_n   = S_PRIME;
            src_n     = src_sel;
            dx_n      = dst_x;
            dy_n      = dst_y;
            key_n     = key_en;
            k_n       = '0;
            holding_n = 1'b0;
          end
        end
      end
      S_PRIME: begin
        state_n    = S_RUN;
        rom_addr_n = 10'd1;
      end
      S_RUN: begin
        if (cpu_vram_we) begin
          // Stall: keep the already-returned ROM word, since the ROM moves on to k+1
          if (!holding) begin
            hold_n    = rom_q;
            holding_n = 1'b1;
          end
        end else begin
          holding_n = 1'b0;
          if (px_keep) begin
            vram_we_n   = 1'b1;
            vram_addr_n = px_addr;
            vram_data_n = px_data;
          end
          if (k == K_LAST) begin
            state_n = S_DONE;
          end else begin
            k_n = k + 10'd1;
          end
          rom_addr_n = (k_plus2 > 11'(K_LAST)) ? K_LAST : k_plus2[KW-1:0];
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (cpu_vram_we) begin
      vram_we_n   = 1'b1;
      vram_addr_n = cpu_vram_addr;
      vram_data_n = cpu_vram_data;
    end

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      k               <= '0;
      rom_addr        <= '0;
      src             <= '0;
      dx              <= '0;
      dy              <= '0;
      key             <= 1'b0;
      hold            <= '0;
      holding         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      background_addr <= '0;
      character_addr  <= '0;
      wall_addr       <= '0;
      vram_we         <= 1'b0;
      vram_addr       <= '0;
      vram_data       <= '0;
    end else begin
      state           <= state_n;
      k               <= k_n;
      rom_addr        <= rom_addr_n;
      src             <= src_n;
      dx              <= dx_n;
      dy              <= dy_n;
      key             <= key_n;
      hold            <= hold_n;
      holding         <= holding_n;
      busy            <= busy_n;
      done            <= done_n;
      err             <= err_n;
      background_addr <= (src_n == SRC_BG)   ? rom_addr_n : '0;
      character_addr  <= (src_n == SRC_CHR)  ? rom_addr_n : '0;
      wall_addr       <= (src_n == SRC_WALL) ? rom_addr_n : '0;
      vram_we         <= vram_we_n;
      vram_addr       <= vram_addr_n;
      vram_data       <= vram_data_n;
    end
  end

endmodule

// File: tb/tb_vram_tile_blitter.sv
// Bench for vram_tile_blitter: a schedule model computes every expected VRAM write and
// busy/done/err value per cycle from the tile rules; one negedge process compares.
module tb_vram_tile_blitter;

  localparam int LEN = 1300;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  src_sel;
  logic [9:0]  dst_x;
  logic [8:0]  dst_y;
  logic        key_en;
  logic        busy, done, err;
  logic        cpu_vram_we;
  logic [17:0] cpu_vram_addr;
  logic [11:0] cpu_vram_data;
  logic [9:0]  background_addr, character_addr, wall_addr;
  logic [11:0] background_data, character_data, wall_data;
  logic        vram_we;
  logic [17:0] vram_addr;
  logic [11:0] vram_data;

  vram_tile_blitter dut (
    .clk(clk), .rst(rst), .start(start), .src_sel(src_sel),
    .dst_x(dst_x), .dst_y(dst_y), .key_en(key_en),
    .busy(busy), .done(done), .err(err),
    .cpu_vram_we(cpu_vram_we), .cpu_vram_addr(cpu_vram_addr), .cpu_vram_data(cpu_vram_data),
    .background_addr(background_addr), .background_data(background_data),
    .character_addr(character_addr), .character_data(character_data),
    .wall_addr(wall_addr), .wall_data(wall_data),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [3][1024];
  always @(posedge clk) begin
    background_data <= rom[0][background_addr];
    character_data  <= rom[1][character_addr];
    wall_data       <= rom[2][wall_addr];
  end

  // CPU traffic schedule, relative to the start cycle
  bit          cpu_at [LEN];
  logic [17:0] cpu_a  [LEN];
  logic [11:0] cpu_d  [LEN];

  // Expected outputs per relative cycle
  int exp_we [LEN];
  int exp_addr [LEN];
  int exp_data [LEN];
  int exp_busy [LEN];
  int exp_done [LEN];
  int exp_err [LEN];
  int done_t;
  int n_exp_w;

  int checks = 0;
  int errors = 0;
  int nprint = 0;
  bit chk_en = 1'b0;
  int t_cur = 0;
  int obs_we = 0;
  int obs_done_t = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (nprint < 40) begin
        nprint++;
        $display("FAIL %s t=%0d got %0h expected %0h", name, t_cur, act, expv);
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("vram_we", 32'(vram_we), exp_we[t_cur]);
      if (exp_we[t_cur] != 0) begin
        check("vram_addr", 32'(vram_addr), exp_addr[t_cur]);
        check("vram_data", 32'(vram_data), exp_data[t_cur]);
      end
      check("busy", 32'(busy), exp_busy[t_cur]);
      check("done", 32'(done), exp_done[t_cur]);
      check("err", 32'(err), exp_err[t_cur]);
      if (vram_we) obs_we++;
      if (done) obs_done_t = t_cur;
    end
  end

  task automatic clear_cpu();
    for (int t = 0; t < LEN; t++) begin
      cpu_at[t] = 1'b0;
      cpu_a[t]  = 18'($urandom);
      cpu_d[t]  = 12'($urandom);
    end
  endtask

  // Schedule model: pixel k is consumed on the k-th non-CPU cycle from relative cycle 2
  task automatic build(input int src, input int dx, input int dy, input int key,
                       input int legal, input int rst_t);
    int c, x, y, d;
    n_exp_w = 0;
    for (int t = 0; t < LEN; t++) begin
      exp_we[t] = 0; exp_addr[t] = 0; exp_data[t] = 0;
      exp_busy[t] = 0; exp_done[t] = 0; exp_err[t] = 0;
    end
    for (int t = 0; t < LEN - 1; t++)
      if (cpu_at[t]) begin
        exp_we[t+1] = 1; exp_addr[t+1] = int'(cpu_a[t]); exp_data[t+1] = int'(cpu_d[t]);
      end
    if (legal == 0) begin
      exp_done[1] = 1; exp_err[1] = 1; done_t = 1;
    end else begin
      c = 2;
      for (int k = 0; k < 1024; k++) begin
        while (c < LEN - 3 && cpu_at[c]) c++;
        x = dx + (k % 32);
        y = dy + (k / 32);
        d = int'(rom[src][k]);
        if (x < 640 && y < 400 && !(key != 0 && d == 0)) begin
          exp_we[c+1] = 1;
          exp_addr[c+1] = (y * 640 + x) % 262144;
          exp_data[c+1] = d;
          n_exp_w++;
        end
        c++;
      end
      done_t = c + 1;
      for (int t = 1; t < done_t; t++) exp_busy[t] = 1;
      exp_done[done_t] = 1;
    end
    if (rst_t >= 0) begin
      for (int t = rst_t + 1; t < LEN; t++) begin
        exp_we[t] = 0; exp_busy[t] = 0; exp_done[t] = 0; exp_err[t] = 0;
      end
      if (done_t > rst_t) done_t = -1;
    end
  endtask

  task automatic run(input int src, input int dx, input int dy, input int key,
                     input int rst_t, input int busy_start_t, input int ncycles, input bit pin);
    obs_we = 0;
    obs_done_t = -1;
    chk_en = 1'b1;
    for (int t = 0; t < ncycles; t++) begin
      t_cur = t;
      start = (t == 0) || (t == busy_start_t);
      src_sel = (t == 0) ? 2'(src) : 2'($urandom);
      dst_x = (t == 0) ? 10'(dx) : 10'($urandom);
      dst_y = (t == 0) ? 9'(dy) : 9'($urandom);
      key_en = (t == 0) ? 1'(key) : 1'($urandom);
      rst = (t == rst_t);
      cpu_vram_we = cpu_at[t];
      cpu_vram_addr = cpu_a[t];
      cpu_vram_data = cpu_d[t];
      if (pin && t == 10) begin
        #3;
        check("character_addr_t10", 32'(character_addr), 32'd9);
        check("background_addr_idle_src", 32'(background_addr), 32'd0);
        check("wall_addr_idle_src", 32'(wall_addr), 32'd0);
      end
      if (rst_t >= 0 && t == rst_t + 1) begin
        #3;
        check("rst_vram_addr", 32'(vram_addr), 32'd0);
        check("rst_vram_data", 32'(vram_data), 32'd0);
        check("rst_bg_addr", 32'(background_addr), 32'd0);
        check("rst_chr_addr", 32'(character_addr), 32'd0);
        check("rst_wall_addr", 32'(wall_addr), 32'd0);
      end
      @(posedge clk); #1;
    end
    chk_en = 1'b0;
    start = 1'b0;
    rst = 1'b0;
    cpu_vram_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      start = 1'b0;
      cpu_vram_we = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int cnt, tt, s, dx, dy;
    rst = 1'b1; start = 1'b0; src_sel = '0; dst_x = '0; dst_y = '0; key_en = 1'b0;
    cpu_vram_we = 1'b0; cpu_vram_addr = '0; cpu_vram_data = '0;
    for (int k = 0; k < 1024; k++)
      for (int r = 0; r < 3; r++) rom[r][k] = 12'(k);
    clear_cpu();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_vram_we", 32'(vram_we), 32'd0);
    check("reset_vram_addr", 32'(vram_addr), 32'd0);
    check("reset_chr_addr", 32'(character_addr), 32'd0);
    rst = 1'b0;
    idle(2);

    // Identity ROM, character source at origin; an ignored start lands mid-blit
    build(1, 0, 0, 0, 1, -1);
    check("model_writes_t1", n_exp_w, 1024);
    check("model_done_t1", done_t, 1027);
    check("model_px37_addr", exp_addr[40], 645);
    check("model_px37_data", exp_data[40], 37);
    run(1, 0, 0, 0, -1, 500, done_t + 3, 1'b1);
    check("obs_writes_t1", obs_we, 1024);
    check("obs_done_t1", obs_done_t, 1027);
    idle(3);

    // Five CPU writes mid-RUN
    clear_cpu();
    cnt = 0;
    while (cnt < 5) begin
      tt = $urandom_range(100, 900);
      if (!cpu_at[tt]) begin cpu_at[tt] = 1'b1; cnt++; end
    end
    build(1, 0, 0, 0, 1, -1);
    check("model_done_t2", done_t, 1032);
    run(1, 0, 0, 0, -1, -1, done_t + 3, 1'b0);
    check("obs_writes_t2", obs_we, 1029);
    check("obs_done_t2", obs_done_t, 1032);
    idle(3);

    // Clipping at the bottom-right corner
    clear_cpu();
    for (int k = 0; k < 1024; k++) rom[0][k] = 12'($urandom);
    build(0, 620, 390, 0, 1, -1);
    check("model_writes_t3", n_exp_w, 200);
    run(0, 620, 390, 0, -1, -1, done_t + 3, 1'b0);
    check("obs_writes_t3", obs_we, 200);
    check("obs_done_t3", obs_done_t, 1027);
    idle(3);

    // Colour key: even pixels transparent
    for (int k = 0; k < 1024; k++)
      rom[2][k] = (k % 2 == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
    build(2, 0, 0, 1, 1, -1);
    check("model_writes_t4", n_exp_w, 512);
    run(2, 0, 0, 1, -1, -1, done_t + 3, 1'b0);
    check("obs_writes_t4", obs_we, 512);
    idle(3);

    // Illegal source
    build(0, 0, 0, 0, 0, -1);
    run(3, 5, 5, 0, -1, -1, 5, 1'b0);
    check("obs_done_t5", obs_done_t, 1);
    check("obs_writes_t5", obs_we, 0);
    idle(3);

    // Reset mid-blit, then a fresh blit
    build(0, 10, 20, 0, 1, 500);
    run(0, 10, 20, 0, 500, -1, 510, 1'b0);
    check("obs_done_after_rst", obs_done_t, -1);
    idle(3);
    build(0, 100, 50, 0, 1, -1);
    run(0, 100, 50, 0, -1, -1, done_t + 3, 1'b0);
    check("obs_done_post_rst", obs_done_t, 1027);
    idle(3);

    // Random blits with random CPU traffic
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 1024; k++)
          rom[r][k] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
      clear_cpu();
      for (int t = 0; t < LEN; t++) cpu_at[t] = ($urandom_range(0, 99) < 8);
      s = $urandom_range(0, 2);
      dx = $urandom_range(0, 1023);
      dy = $urandom_range(0, 511);
      tt = $urandom_range(0, 1);
      build(s, dx, dy, tt, 1, -1);
      run(s, dx, dy, tt, -1, $urandom_range(100, 900), done_t + 3, 1'b0);
      check("obs_done_rand", obs_done_t, done_t);
      idle(3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
